mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one multiplier/result-memory block between two operand requesters.
- Grants operand pairs round-robin and feeds exactly 2^LOGDEPTH products per batch.
- Records a per-slot requester tag, then triggers a block read.
- Returns each stored product tagged with the requester that issued it.

Parameters:
LOGDEPTH, 6, log2 of batch size / result memory depth (batch = 64 products)
OPW, 16, operand width per multiplier input
WIDTH, 32, product/result width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  requester 0 pair accepted this cycle
req0_a  input  OPW  requester 0 operand A
req0_b  input  OPW  requester 0 operand B
req1_valid  input  1  requester 1 has an operand pair
req1_ready  output  1  requester 1 pair accepted this cycle
req1_a  input  OPW  requester 1 operand A
req1_b  input  OPW  requester 1 operand B
EN_mult  output  1  issue the current operand pair to the multiplier
RDY_mult  input  1  multiplier can accept a pair
mult_input0  output  OPW  operand A to the multiplier
mult_input1  output  OPW  operand B to the multiplier
EN_blockRead  output  1  one-cycle pulse starting the block read
VALID_memVal  input  1  memVal_data is valid this cycle
memVal_data  input  WIDTH  product read back from memory
res_valid  output  1  result beat valid
res_data  output  WIDTH  product
res_id  output  1  requester that issued this product
batch_count  output  LOGDEPTH+1  products issued in the current batch
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT_FULL, DRAIN.
- Reset values:
  - state = IDLE.
  - All outputs 0: ready signals, EN_mult, mult_input0/1, EN_blockRead, res_*, batch_count, busy.
  - Priority pointer = 0 (requester 0 favoured first).
  - Read index = 0.
- Reset mid-batch or mid-drain aborts immediately; all tags are discarded.
- IDLE -> ISSUE on the first cycle where RDY_mult = 1.
- Grant in ISSUE (combinational):
  - Grant goes to the valid requester.
  - If both are valid, grant goes to the pointer's requester.
  - fire = ISSUE && RDY_mult && (req0_valid || req1_valid) && batch_count < 2^LOGDEPTH.
  - EN_mult = fire. reqN_ready = fire && grantN. Never both readies high.
  - mult_input0/1 = granted operands when fire, else 0.
- On a fire edge:
  - tag[batch_count] <= granted id.
  - batch_count++.
  - Pointer <= the other (non-granted) requester.
- Without fire, pointer and count hold.
- The transfer that makes batch_count = 2^LOGDEPTH moves ISSUE -> WAIT_FULL. No further fires.
- WAIT_FULL lasts one cycle.
  - Then EN_blockRead pulses high for exactly one cycle and the state moves to DRAIN.
- DRAIN:
  - Each cycle with VALID_memVal = 1 produces, next cycle: res_valid = 1, res_data = memVal_data, res_id = tag[read index]. Then read index++.
  - Result latency is 1 cycle. There is no backpressure; the consumer must accept every beat.
  - VALID_memVal outside DRAIN is ignored.
- After the 2^LOGDEPTH-th beat: batch_count <= 0, read index <= 0, state -> IDLE. The pointer is preserved across batches.
- Wrap-around: the read index wraps 63 -> 0 only via the IDLE transition. Extra VALID beats are ignored.
- A requester holding valid without a grant must keep its operands stable (valid/ready handshake).

Test Plan:
- Only req0 valid, 64 pairs a = i, b = 2 -> 64 fires, all res_id = 0, res_data = 2i in order, one EN_blockRead pulse.
- Both valid continuously -> grants alternate 0, 1, 0, 1 starting with 0; tags alternate; res_id pattern 0101…; 32 products per requester.
- RDY_mult low for 5 cycles mid-batch with both valid -> no fire, no ready, pointer and batch_count hold; issue resumes from the correct requester.
- req1 only for the first 10 fires, then both -> pointer is 0 after each req1 grant, so req0 wins the first contested cycle.
- rst asserted for 1 cycle at drain beat 20 -> all outputs 0, IDLE next cycle, the following batch restarts tag slot 0.
- Extra VALID_memVal beats after 64 results -> no res_valid, state stays IDLE.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Two-requester front end for a shared multiplier and result memory.
// Operand pairs are granted round-robin until a full batch of 2^LOGDEPTH
// products has been issued. A one-cycle block-read pulse then starts the
// read-back, and every returned product is tagged with the requester that
// issued it.
module mult_share_arbiter #(
  parameter int unsigned LOGDEPTH = 6,
  parameter int unsigned OPW      = 16,
  parameter int unsigned WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  // Requester 0
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OPW-1:0]      req0_a,
  input  logic [OPW-1:0]      req0_b,
  // Requester 1
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OPW-1:0]      req1_a,
  input  logic [OPW-1:0]      req1_b,
  // Multiplier issue side
  output logic                EN_mult,
  input  logic                RDY_mult,
  output logic [OPW-1:0]      mult_input0,
  output logic [OPW-1:0]      mult_input1,
  // Result memory read side
  output logic                EN_blockRead,
  input  logic                VALID_memVal,
  input  logic [WIDTH-1:0]    memVal_data,
  // Tagged results
  output logic                res_valid,
  output logic [WIDTH-1:0]    res_data,
  output logic                res_id,
  // Status
  output logic [LOGDEPTH:0]   batch_count,
  output logic                busy
);

  localparam int unsigned Depth = 1 << LOGDEPTH;
  localparam logic [LOGDEPTH:0] DepthCnt = Depth[LOGDEPTH:0];

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitFull,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;         // requester favoured on contention
  logic [LOGDEPTH:0]     count_q, count_d;     // products issued in this batch
  logic [LOGDEPTH-1:0]   rd_idx_q, rd_idx_d;   // next tag slot to return
  logic [Depth-1:0]      tag_q, tag_d;         // issuing requester per memory slot
  logic                  blk_rd_q, blk_rd_d;
  logic                  res_valid_q, res_valid_d;
  logic [WIDTH-1:0]      res_data_q, res_data_d;
  logic                  res_id_q, res_id_d;

  logic                  any_valid;
  logic                  grant_id;
  logic                  fire;

  // Round-robin grant and issue qualification. Reset suppresses issue so an
  // aborted batch never handshakes a pair it is about to discard.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = req1_valid & (~req0_valid | ptr_q);
    fire      = (state_q == StIssue) & ~rst & RDY_mult & any_valid & (count_q < DepthCnt);
  end

  // Multiplier and requester handshake outputs; operands are zero when idle.
  always_comb begin
    EN_mult     = fire;
    req0_ready  = fire & ~grant_id;
    req1_ready  = fire & grant_id;
    mult_input0 = '0;
    mult_input1 = '0;
    if (fire) begin
      mult_input0 = grant_id ? req1_a : req0_a;
      mult_input1 = grant_id ? req1_b : req0_b;
    end
  end

  // Next-state logic for the batch controller, tag store and result stage.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    tag_d       = tag_q;
    blk_rd_d    = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = '0;
    res_id_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (RDY_mult) begin
          state_d = StIssue;
        end
      end

      StIssue: begin
        if (fire) begin
          tag_d[count_q[LOGDEPTH-1:0]] = grant_id;
          count_d                      = count_q + 1'b1;
          ptr_d                        = ~grant_id;
          if (count_q == DepthCnt - 1'b1) begin
            state_d = StWaitFull;
          end
        end
      end

      // One settling cycle after the last issue, then kick the block read.
      StWaitFull: begin
        blk_rd_d = 1'b1;
        state_d  = StDrain;
      end

      StDrain: begin
        if (VALID_memVal) begin
          res_valid_d = 1'b1;
          res_data_d  = memVal_data;
          res_id_d    = tag_q[rd_idx_q];
          rd_idx_d    = rd_idx_q + 1'b1;
          // Last slot returned: close the batch; the pointer carries over.
          if (rd_idx_q == '1) begin
            state_d  = StIdle;
            count_d  = '0;
            rd_idx_d = '0;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any batch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      count_q     <= '0;
      rd_idx_q    <= '0;
      tag_q       <= '0;
      blk_rd_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      tag_q       <= tag_d;
      blk_rd_q    <= blk_rd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign EN_blockRead = blk_rd_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_id       = res_id_q;
  assign batch_count  = count_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter with a behavioural model, a
// multiplier/memory responder and a few literal checks on grant/result order.
module tb_mult_share_arbiter;

  localparam int unsigned LOGDEPTH = 6;
  localparam int unsigned OPW      = 16;
  localparam int unsigned WIDTH    = 32;
  localparam int          Depth    = 64;

  logic               clk;
  logic               rst;
  logic               req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0]     req0_a, req0_b, req1_a, req1_b;
  logic               EN_mult, RDY_mult;
  logic [OPW-1:0]     mult_input0, mult_input1;
  logic               EN_blockRead, VALID_memVal;
  logic [WIDTH-1:0]   memVal_data;
  logic               res_valid, res_id;
  logic [WIDTH-1:0]   res_data;
  logic [LOGDEPTH:0]  batch_count;
  logic               busy;

  mult_share_arbiter #(
    .LOGDEPTH(LOGDEPTH),
    .OPW     (OPW),
    .WIDTH   (WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .EN_mult     (EN_mult),
    .RDY_mult    (RDY_mult),
    .mult_input0 (mult_input0),
    .mult_input1 (mult_input1),
    .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal),
    .memVal_data (memVal_data),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_id      (res_id),
    .batch_count (batch_count),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus controls (written by the main process between edges)
  logic [OPW-1:0] q0a[$], q0b[$], q1a[$], q1b[$];
  bit  hold0 = 0, hold1 = 0;
  int  p_valid = 100, rdy_pct = 100, mem_pct = 100;
  int  rdy_low_cnt = 0, rst_req = 3, extra_left = 0;
  bit  flush_req = 0;

  // Multiplier + result memory responder
  logic [WIDTH-1:0] mem [Depth];
  int  wptr = 0, sidx = 0;
  bit  streaming = 0;

  // Observation logs for literal checks
  bit               gnt_log[$];
  logic [WIDTH-1:0] res_log_d[$];
  bit               res_log_id[$];
  int               blk_cnt = 0;

  // Input driver: everything changes 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (flush_req) begin
      q0a.delete(); q0b.delete(); q1a.delete(); q1b.delete();
      hold0 = 0; hold1 = 0; extra_left = 0; flush_req = 0;
    end
    rst = (rst_req > 0);
    if (rst_req > 0) rst_req--;
    if (rst) begin
      streaming = 0; wptr = 0; sidx = 0;
    end
    if (rdy_low_cnt > 0) begin
      RDY_mult = 1'b0;
      rdy_low_cnt--;
    end else begin
      RDY_mult = ($urandom_range(99) < rdy_pct);
    end
    if (!hold0) begin
      if (q0a.size() > 0 && $urandom_range(99) < p_valid) begin
        req0_valid = 1'b1; req0_a = q0a[0]; req0_b = q0b[0]; hold0 = 1;
      end else begin
        req0_valid = 1'b0; req0_a = OPW'($urandom); req0_b = OPW'($urandom);
      end
    end
    if (!hold1) begin
      if (q1a.size() > 0 && $urandom_range(99) < p_valid) begin
        req1_valid = 1'b1; req1_a = q1a[0]; req1_b = q1b[0]; hold1 = 1;
      end else begin
        req1_valid = 1'b0; req1_a = OPW'($urandom); req1_b = OPW'($urandom);
      end
    end
    VALID_memVal = 1'b0;
    memVal_data  = WIDTH'($urandom);
    if (streaming && sidx == Depth) begin
      streaming = 0; wptr = 0;
    end
    if (!rst) begin
      if (streaming) begin
        if ($urandom_range(99) < mem_pct) begin
          VALID_memVal = 1'b1; memVal_data = mem[sidx]; sidx++;
        end
      end else if (extra_left > 0) begin
        VALID_memVal = 1'b1; extra_left--;
      end
    end
  end

  // Monitor: handshakes, multiplier writes, block-read start, result log.
  always @(negedge clk) begin
    if (EN_mult === 1'b1) begin
      if (wptr < Depth) mem[wptr] = WIDTH'(mult_input0) * WIDTH'(mult_input1);
      wptr++;
      gnt_log.push_back(req1_ready === 1'b1);
    end
    if (req0_ready === 1'b1 && q0a.size() > 0) begin
      void'(q0a.pop_front()); void'(q0b.pop_front()); hold0 = 0;
    end
    if (req1_ready === 1'b1 && q1a.size() > 0) begin
      void'(q1a.pop_front()); void'(q1b.pop_front()); hold1 = 0;
    end
    if (EN_blockRead === 1'b1) begin
      streaming = 1; sidx = 0; blk_cnt++;
    end
    if (res_valid === 1'b1) begin
      res_log_d.push_back(res_data);
      res_log_id.push_back(res_id === 1'b1);
    end
  end

  // Behavioural model: a batch is a list of issued (requester, product)
  // entries; results come back in issue order, one per memory beat.
  bit               m_active = 0, m_drain = 0, m_ptr = 0, m_blk = 0;
  bit               m_rv = 0, m_rid = 0, m_after_rst = 0;
  int               m_issued = 0, m_returned = 0, m_batches = 0;
  logic [WIDTH-1:0] m_rd = '0;
  bit               m_tags[$];
  logic [WIDTH-1:0] ep0[$], ep1[$];

  // Compare DUT outputs against the model, then advance the model by the
  // inputs the DUT will sample at the next rising edge.
  always @(negedge clk) begin : cmp
    bit issuing, waiting, fire, gid;
    logic [OPW-1:0] ea, eb;
    issuing = m_active && !m_drain && (m_issued < Depth);
    waiting = m_active && !m_drain && (m_issued == Depth);
    gid     = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    fire    = issuing && !rst && RDY_mult && (req0_valid || req1_valid);
    ea      = fire ? (gid ? req1_a : req0_a) : '0;
    eb      = fire ? (gid ? req1_b : req0_b) : '0;

    chk("EN_mult", EN_mult, fire);
    chk("req0_ready", req0_ready, fire && !gid);
    chk("req1_ready", req1_ready, fire && gid);
    chk("mult_input0", mult_input0, ea);
    chk("mult_input1", mult_input1, eb);
    chk("EN_blockRead", EN_blockRead, m_blk);
    chk("res_valid", res_valid, m_rv);
    if (m_rv) begin
      chk("res_data", res_data, m_rd);
      chk("res_id", res_id, m_rid);
    end
    if (m_after_rst) begin
      chk("res_data_rst", res_data, 0);
      chk("res_id_rst", res_id, 0);
    end
    chk("batch_count", batch_count, m_issued);
    chk("busy", busy, m_active);

    if (rst) begin
      m_active = 0; m_drain = 0; m_ptr = 0; m_issued = 0; m_returned = 0;
      m_tags.delete(); ep0.delete(); ep1.delete();
      m_blk = 0; m_rv = 0; m_rd = '0; m_rid = 0; m_after_rst = 1;
    end else begin
      m_after_rst = 0; m_blk = 0; m_rv = 0;
      if (!m_active) begin
        if (RDY_mult) m_active = 1;
      end else if (issuing) begin
        if (fire) begin
          m_tags.push_back(gid);
          if (gid) ep1.push_back(WIDTH'(ea) * WIDTH'(eb));
          else     ep0.push_back(WIDTH'(ea) * WIDTH'(eb));
          m_issued++;
          m_ptr = !gid;
        end
      end else if (waiting) begin
        m_drain = 1; m_blk = 1;
      end else if (VALID_memVal) begin
        m_rv  = 1;
        m_rid = m_tags[m_returned];
        if (m_rid && ep1.size() > 0)       m_rd = ep1.pop_front();
        else if (!m_rid && ep0.size() > 0) m_rd = ep0.pop_front();
        else                               m_rd = 'x;
        m_returned++;
        if (m_returned == Depth) begin
          m_active = 0; m_drain = 0; m_issued = 0; m_returned = 0;
          m_tags.delete(); m_batches++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); res_log_d.delete(); res_log_id.delete(); blk_cnt = 0;
  endtask

  task automatic reset_flush();
    rst_req = 1; flush_req = 1;
    repeat (3) cyc();
    clear_logs();
  endtask

  task automatic fill(input bit which, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) begin q1a.push_back(OPW'($urandom)); q1b.push_back(OPW'($urandom)); end
      else       begin q0a.push_back(OPW'($urandom)); q0b.push_back(OPW'($urandom)); end
    end
  endtask

  task automatic wait_batch(input string name, input int budget);
    int start;
    int n;
    start = m_batches;
    n = 0;
    while (m_batches == start && n < budget) begin
      cyc(); n++;
    end
    chk({name, "_batch_done"}, (m_batches != start), 1);
    cyc(); cyc();
  endtask

  // First 64 grants must alternate 0,1,0,1...
  task automatic chk_gnt_alt(input string name);
    int bad;
    bad = 0;
    if (gnt_log.size() < Depth) bad = Depth;
    else for (int i = 0; i < Depth; i++) if (gnt_log[i] != bit'(i % 2)) bad++;
    chk(name, bad, 0);
  endtask

  task automatic chk_res_alt(input string name);
    int bad;
    bad = 0;
    if (res_log_id.size() != Depth) bad = Depth;
    else for (int i = 0; i < Depth; i++) if (res_log_id[i] != bit'(i % 2)) bad++;
    chk(name, bad, 0);
  endtask

  initial begin
    int bad, snap_c, snap_g, n;
    rst = 1'b1;
    req0_valid = 0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0;
    RDY_mult = 0; VALID_memVal = 0; memVal_data = '0;
    repeat (4) cyc();
    chk("reset_busy", busy, 0);
    chk("reset_batch_count", batch_count, 0);

    // 1: requester 0 alone, a = i, b = 2
    clear_logs();
    for (int i = 0; i < Depth; i++) begin
      q0a.push_back(OPW'(i)); q0b.push_back(OPW'(2));
    end
    wait_batch("t1", 600);
    chk("t1_res_count", res_log_d.size(), Depth);
    bad = 0;
    for (int i = 0; i < res_log_d.size(); i++)
      if (res_log_d[i] !== WIDTH'(2 * i) || res_log_id[i] != 0) bad++;
    chk("t1_res_pattern", bad, 0);
    bad = 0;
    foreach (gnt_log[i]) if (gnt_log[i]) bad++;
    chk("t1_no_req1_grant", bad, 0);
    chk("t1_blockread_pulses", blk_cnt, 1);

    // 2: both continuously valid
    reset_flush();
    mem_pct = 70;
    fill(0, 40); fill(1, 40);
    wait_batch("t2", 800);
    chk_gnt_alt("t2_grant_alternation");
    chk_res_alt("t2_res_id_alternation");
    bad = 0;
    foreach (res_log_id[i]) if (!res_log_id[i]) bad++;
    chk("t2_req0_products", bad, 32);
    chk("t2_blockread_pulses", blk_cnt, 1);

    // 3: multiplier stalls for 5 cycles mid-batch
    reset_flush();
    fill(0, 40); fill(1, 40);
    n = 0;
    while (m_issued < 20 && n < 300) begin cyc(); n++; end
    chk("t3_reach_20", (m_issued >= 20), 1);
    rdy_low_cnt = 5;
    cyc();
    snap_c = m_issued;
    snap_g = gnt_log.size();
    repeat (5) cyc();
    chk("t3_count_hold", batch_count, snap_c);
    chk("t3_no_fire_in_stall", gnt_log.size(), snap_g);
    wait_batch("t3", 800);
    chk_gnt_alt("t3_grant_alternation");

    // 4: req1 alone for 10 fires, then both contend
    reset_flush();
    rdy_pct = 75;
    fill(1, 10);
    n = 0;
    while (gnt_log.size() < 10 && n < 300) begin cyc(); n++; end
    fill(0, 60); fill(1, 60);
    wait_batch("t4", 1000);
    bad = 0;
    if (gnt_log.size() < 11) bad = 11;
    else for (int i = 0; i < 10; i++) if (!gnt_log[i]) bad++;
    chk("t4_first_ten_req1", bad, 0);
    chk("t4_first_contest_req0", (gnt_log.size() > 10) ? gnt_log[10] : 1'bx, 0);

    // 5: reset in the middle of the drain
    reset_flush();
    rdy_pct = 100; mem_pct = 100;
    fill(0, 80); fill(1, 80);
    n = 0;
    while (m_returned < 20 && n < 400) begin cyc(); n++; end
    chk("t5_reach_beat20", (m_returned >= 20), 1);
    rst_req = 1;
    cyc(); cyc();
    clear_logs();
    chk("t5_busy", busy, 0);
    chk("t5_batch_count", batch_count, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_blockread", EN_blockRead, 0);
    chk("t5_res_data", res_data, 0);
    wait_batch("t5", 800);
    chk_gnt_alt("t5_grant_alternation");
    chk_res_alt("t5_res_id_restart");

    // 6: extra memory beats after the batch is complete
    reset_flush();
    for (int i = 0; i < Depth; i++) begin
      q0a.push_back(OPW'(i)); q0b.push_back(OPW'(i + 7));
    end
    n = 0;
    while (m_issued < Depth && n < 400) begin cyc(); n++; end
    rdy_pct = 0;
    wait_batch("t6", 600);
    extra_left = 6;
    repeat (12) cyc();
    chk("t6_res_count", res_log_d.size(), Depth);
    chk("t6_busy", busy, 0);
    chk("t6_batch_count", batch_count, 0);

    // 7: random traffic over two back-to-back batches
    reset_flush();
    p_valid = 60; rdy_pct = 70; mem_pct = 60;
    fill(0, 80); fill(1, 80);
    wait_batch("t7a", 1500);
    wait_batch("t7b", 1500);
    chk("t7_blockread_pulses", blk_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
